// File: rtl/sm83_int_ctl.sv
`default_nettype none
// ============================================================================
// Module   : sm83_int_ctl
// Purpose  : SM83 interrupt controller. Latches rising edges of peripheral
//            request lines into IF (0xFF0F), holds the IE mask (0xFFFF),
//            answers CPU bus reads/writes to both registers, and supplies the
//            RST vector of the highest-priority pending source on the core's
//            interrupt-acknowledge pulse. IME lives in the core.
// Ports    : clk, rst_n                 clock, synchronous active-low reset
//            irq_src[4:0]               level requests (0 VBlank .. 4 Joypad)
//            bus_addr/bus_wdata         CPU address / write data
//            bus_wr/bus_rd              one-cycle access strobes
//            bus_rdata/bus_rvalid       registered read response
//            int_pending                (IE & IF) != 0, for HALT wake
//            int_ack                    dispatch-start pulse from core
//            int_vec/int_vec_valid      vector low byte + one-cycle qualifier
// Revision : 1.0 - initial release
// ============================================================================
module sm83_int_ctl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  irq_src,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_wr,
  input  logic        bus_rd,
  output logic [7:0]  bus_rdata,
  output logic        bus_rvalid,
  output logic        int_pending,
  input  logic        int_ack,
  output logic [7:0]  int_vec,
  output logic        int_vec_valid
);

  localparam int          N_SRC     = 5;
  localparam logic [15:0] C_ADDR_IF = 16'hFF0F;
  localparam logic [15:0] C_ADDR_IE = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_VEC  = 1'b1
  } state_t;

  // Registered state
  state_t            state_q,         state_d;
  logic [N_SRC-1:0]  if_q,            if_d;
  logic [7:0]        ie_q,            ie_d;
  logic [N_SRC-1:0]  src_q,           src_d;
  logic [7:0]        bus_rdata_q,     bus_rdata_d;
  logic              bus_rvalid_q,    bus_rvalid_d;
  logic [7:0]        int_vec_q,       int_vec_d;
  logic              int_vec_valid_q, int_vec_valid_d;

  // Combinational helpers
  logic [N_SRC-1:0]  edge_w;
  logic [N_SRC-1:0]  pend_w;
  logic              found_w;
  logic [2:0]        k_w;
  logic              ack_take_w;
  logic [N_SRC-1:0]  ack_clr_w;
  logic              wr_if_w;
  logic              wr_ie_w;
  logic              rd_if_w;
  logic              rd_ie_w;

  always_comb begin
    edge_w  = irq_src & ~src_q;
    pend_w  = ie_q[N_SRC-1:0] & if_q;
    wr_if_w = bus_wr && (bus_addr == C_ADDR_IF);
    wr_ie_w = bus_wr && (bus_addr == C_ADDR_IE);
    rd_if_w = bus_rd && (bus_addr == C_ADDR_IF);
    rd_ie_w = bus_rd && (bus_addr == C_ADDR_IE);

    // Lowest set bit wins: scan from the top so the last hit is the lowest.
    found_w = 1'b0;
    k_w     = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pend_w[i]) begin
        found_w = 1'b1;
        k_w     = 3'(i);
      end
    end

    // Acks are only honoured in IDLE; an ack during VEC is dropped.
    ack_take_w = (state_q == ST_IDLE) && int_ack;
    ack_clr_w  = (ack_take_w && found_w) ? (5'b00001 << k_w) : '0;

    // IF: write, then ack clear, then edges -- a fresh edge always survives.
    if_d = if_q;
    if (wr_if_w) begin
      if_d = bus_wdata[N_SRC-1:0];
    end
    if_d = (if_d & ~ack_clr_w) | edge_w;

    ie_d  = wr_ie_w ? bus_wdata : ie_q;
    src_d = irq_src;

    // Reads return the value held before this cycle's update.
    bus_rdata_d  = bus_rdata_q;
    bus_rvalid_d = rd_if_w || rd_ie_w;
    if (rd_if_w) begin
      bus_rdata_d = {3'b111, if_q};
    end else if (rd_ie_w) begin
      bus_rdata_d = ie_q;
    end

    state_d         = state_q;
    int_vec_d       = int_vec_q;
    int_vec_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (int_ack) begin
          // Nothing pending any more (IE/IF changed under dispatch) -> 0x00.
          int_vec_d       = found_w ? (8'h40 + {2'b00, k_w, 3'b000}) : 8'h00;
          int_vec_valid_d = 1'b1;
          state_d         = ST_VEC;
        end
      end
      ST_VEC: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      if_q            <= '0;
      ie_q            <= 8'h00;
      src_q           <= '0;
      bus_rdata_q     <= 8'h00;
      bus_rvalid_q    <= 1'b0;
      int_vec_q       <= 8'h00;
      int_vec_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      if_q            <= if_d;
      ie_q            <= ie_d;
      src_q           <= src_d;
      bus_rdata_q     <= bus_rdata_d;
      bus_rvalid_q    <= bus_rvalid_d;
      int_vec_q       <= int_vec_d;
      int_vec_valid_q <= int_vec_valid_d;
    end
  end

  assign bus_rdata     = bus_rdata_q;
  assign bus_rvalid    = bus_rvalid_q;
  assign int_vec       = int_vec_q;
  assign int_vec_valid = int_vec_valid_q;
  assign int_pending   = |pend_w;

endmodule
`default_nettype wire
